// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core, loader and memory-side signal bundle for dmem_arbiter

interface dmem_arbiter_if #(
  parameter int width = 32
);

  // Port 0: processor core
  logic             p0_req;
  logic             p0_we;
  logic [width-1:0] p0_addr;
  logic [width-1:0] p0_wdata;
  logic             p0_ack;
  logic             p0_rvalid;
  logic [width-1:0] p0_rdata;
  logic             p0_stall;

  // Port 1: loader / debug master
  logic             p1_req;
  logic             p1_we;
  logic [width-1:0] p1_addr;
  logic [width-1:0] p1_wdata;
  logic             p1_ack;
  logic             p1_rvalid;
  logic [width-1:0] p1_rdata;

  // Shared data-memory port
  logic             mem_write;
  logic             mem_read;
  logic [width-1:0] mem_address;
  logic [width-1:0] mem_write_data;
  logic [width-1:0] mem_read_data;

  // Current bus owner: 00 none, 01 core, 10 loader
  logic [1:0]       owner;

  // Arbiter view
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rvalid, p0_rdata, p0_stall,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rvalid, p1_rdata,
    output mem_write, mem_read, mem_address, mem_write_data,
    input  mem_read_data,
    output owner
  );

  // Requesters and memory view
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rvalid, p0_rdata, p0_stall,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rvalid, p1_rdata,
    input  mem_write, mem_read, mem_address, mem_write_data,
    output mem_read_data,
    input  owner
  );

endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, optional burst lock via DMEM_ARB_BURST_LOCK_EN

module dmem_arbiter #(
  parameter int width     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P0   = 2'b01;
  localparam logic [1:0] OWN_P1   = 2'b10;

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("dmem_arbiter: MAX_BURST must be at least 1");
  end

  logic [1:0]       owner_q;
  logic [1:0]       owner_d;
  logic             last_q;     // 0 = core served last, 1 = loader served last
  logic             last_d;
  logic             ack0;
  logic             ack1;
  logic             elig0;
  logic             elig1;
  logic             keep;       // current owner holds the bus for another cycle
  logic             rvalid0_q;
  logic             rvalid1_q;
  logic [width-1:0] rdata0_q;
  logic [width-1:0] rdata1_q;

  // An owner is only acked while it still holds its request
  assign ack0  = (owner_q == OWN_P0) & bus.p0_req;
  assign ack1  = (owner_q == OWN_P1) & bus.p1_req;

  // A port served this cycle steps aside for the next decision
  assign elig0 = bus.p0_req & ~ack0;
  assign elig1 = bus.p1_req & ~ack1;

`ifdef DMEM_ARB_BURST_LOCK_EN
  localparam int                cnt_w   = $clog2(MAX_BURST + 1);
  localparam logic [cnt_w-1:0]  cnt_max = cnt_w'(MAX_BURST);

  logic [cnt_w-1:0] cnt_q;
  logic [cnt_w-1:0] cnt_after;
  logic             other_req;

  // Ack count including this cycle; an uncontested run wraps back to 1
  assign cnt_after = (cnt_q >= cnt_max) ? cnt_w'(1) : cnt_q + cnt_w'(1);
  assign other_req = ack0 ? bus.p1_req : bus.p0_req;
  assign keep      = (ack0 | ack1) & ~((cnt_after == cnt_max) & other_req);

  // Burst length tracking, cleared whenever ownership is given up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (keep) begin
      cnt_q <= cnt_after;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign keep = 1'b0;
`endif

  // Drive the shared memory port from the acked port only
  always_comb begin
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    if (ack0) begin
      bus.mem_read       = ~bus.p0_we;
      bus.mem_write      = bus.p0_we;
      bus.mem_address    = bus.p0_addr;
      bus.mem_write_data = bus.p0_wdata;
    end else if (ack1) begin
      bus.mem_read       = ~bus.p1_we;
      bus.mem_write      = bus.p1_we;
      bus.mem_address    = bus.p1_addr;
      bus.mem_write_data = bus.p1_wdata;
    end
  end

  // Remember who was served so ties alternate
  always_comb begin
    last_d = last_q;
    if (ack0) begin
      last_d = 1'b0;
    end else if (ack1) begin
      last_d = 1'b1;
    end
  end

  // Pick next owner: burst hold first, then round-robin on ties
  always_comb begin
    owner_d = OWN_NONE;
    if (keep) begin
      owner_d = owner_q;
    end else if (elig0 && elig1) begin
      owner_d = last_q ? OWN_P0 : OWN_P1;
    end else if (elig0) begin
      owner_d = OWN_P0;
    end else if (elig1) begin
      owner_d = OWN_P1;
    end
  end

  // Ownership state; async clear makes acks and strobes drop at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Capture read data on a read ack and flag it valid for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= ack0 & ~bus.p0_we;
      rvalid1_q <= ack1 & ~bus.p1_we;
      if (ack0 && !bus.p0_we) begin
        rdata0_q <= bus.mem_read_data;
      end
      if (ack1 && !bus.p1_we) begin
        rdata1_q <= bus.mem_read_data;
      end
    end
  end

  assign bus.p0_ack    = ack0;
  assign bus.p0_rvalid = rvalid0_q;
  assign bus.p0_rdata  = rdata0_q;
  // Stall is forced low while the core is held in reset
  assign bus.p0_stall  = rst_n & bus.p0_req & ~ack0;

  assign bus.p1_ack    = ack1;
  assign bus.p1_rvalid = rvalid1_q;
  assign bus.p1_rdata  = rdata1_q;

  assign bus.owner     = owner_q;

endmodule
